// File: rtl/kamus_pkg.sv
// Shared core definitions: EX operation codes (including the M extension),
// MDU state encoding and the default datapath width.
package kamus_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OP_ENC_W     = 6;

    typedef enum logic [OP_ENC_W-1:0] {
        OP_ADD    = 6'd0,
        OP_SUB    = 6'd1,
        OP_AND    = 6'd2,
        OP_OR     = 6'd3,
        OP_XOR    = 6'd4,
        OP_SLL    = 6'd5,
        OP_SRL    = 6'd6,
        OP_SRA    = 6'd7,
        OP_SLT    = 6'd8,
        OP_SLTU   = 6'd9,
        OP_MUL    = 6'd32,
        OP_MULH   = 6'd33,
        OP_MULHSU = 6'd34,
        OP_MULHU  = 6'd35,
        OP_DIV    = 6'd36,
        OP_DIVU   = 6'd37,
        OP_REM    = 6'd38,
        OP_REMU   = 6'd39
    } operation_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL,
        MDU_DIV,
        MDU_DONE
    } mdu_state_e;

endpackage

// File: rtl/kamus_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned
// magnitudes. Outputs are the values the registers take after the current step.
module kamus_div_iter
    import kamus_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_bit;

    // r_quo starts as the dividend and shifts its bits into the remainder as
    // quotient bits shift in from the right.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_bit   = ~w_diff[XLEN];
    assign o_rem   = w_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quot  = {r_quo[XLEN-2:0], w_bit};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= o_rem;
            r_quo <= o_quot;
        end
    end

endmodule

// File: rtl/kamus_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the EX stage.
// 2-cycle multiply, XLEN-step restoring divide, single-cycle valid_o result.
module kamus_mdu
    import kamus_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int OP_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [OP_W-1:0] operation_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        r_state;
    operation_e        r_op;
    logic [4:0]        r_rd;
    logic [XLEN:0]     r_mul_a;
    logic [XLEN:0]     r_mul_b;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    operation_e        w_op;
    logic              w_accept;
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_s1_signed;
    logic              w_s2_signed;
    logic              w_sgn1;
    logic              w_sgn2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_div_res;

    assign w_op        = operation_e'(operation_i[OP_ENC_W-1:0]);
    assign w_accept    = valid_i && (r_state == MDU_IDLE) && !flush_i;
    assign w_is_div    = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_is_rem    = w_op inside {OP_REM, OP_REMU};
    assign w_s1_signed = w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_s2_signed = w_op inside {OP_MULH, OP_DIV, OP_REM};
    assign w_sgn1      = w_s1_signed & rs1_data_i[XLEN-1];
    assign w_sgn2      = w_s2_signed & rs2_data_i[XLEN-1];
    assign w_abs1      = w_sgn1 ? -rs1_data_i : rs1_data_i;
    assign w_abs2      = w_sgn2 ? -rs2_data_i : rs2_data_i;

    // Special cases bypass the iteration and complete straight from IDLE.
    assign w_div0    = (rs2_data_i == '0);
    assign w_ovf     = w_s2_signed && (rs1_data_i == MIN_INT) && (rs2_data_i == '1);
    assign w_special = w_div0 ? (w_is_rem ? rs1_data_i : '1)
                              : (w_is_rem ? '0 : rs1_data_i);

    // Low 2*XLEN bits of the (XLEN+1)-bit signed product.
    assign w_mul_a   = {{(XLEN-1){r_mul_a[XLEN]}}, r_mul_a};
    assign w_mul_b   = {{(XLEN-1){r_mul_b[XLEN]}}, r_mul_b};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_div_res = (r_op inside {OP_REM, OP_REMU}) ? (r_neg_r ? -w_rem : w_rem)
                                                      : (r_neg_q ? -w_quo : w_quo);

    kamus_div_iter #(.XLEN(XLEN)) u_div (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_start    (w_accept),
        .i_step     ((r_state == MDU_DIV) && !flush_i),
        .i_dividend (w_abs1),
        .i_divisor  (w_abs2),
        .o_quot     (w_quo),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= MDU_IDLE;
            r_op     <= OP_MUL;
            r_rd     <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_valid <= 1'b0;
            if (flush_i) begin
                r_state <= MDU_IDLE;
            end else begin
                case (r_state)
                    MDU_IDLE: if (valid_i) begin
                        r_op    <= w_op;
                        r_rd    <= rd_addr_i;
                        r_mul_a <= {w_sgn1, rs1_data_i};
                        r_mul_b <= {w_sgn2, rs2_data_i};
                        r_neg_q <= w_sgn1 ^ w_sgn2;
                        r_neg_r <= w_sgn1;
                        r_cnt   <= '0;
                        if (!w_is_div) begin
                            r_state <= MDU_MUL;
                        end else if (w_div0 || w_ovf) begin
                            r_state  <= MDU_DONE;
                            r_result <= w_special;
                            r_rd_out <= rd_addr_i;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= MDU_DIV;
                        end
                    end
                    MDU_MUL: begin
                        r_state  <= MDU_DONE;
                        r_result <= w_mul_res;
                        r_rd_out <= r_rd;
                        r_valid  <= 1'b1;
                    end
                    MDU_DIV: begin
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_state  <= MDU_DONE;
                            r_result <= w_div_res;
                            r_rd_out <= r_rd;
                            r_valid  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= MDU_IDLE;
                endcase
            end
        end
    end

    assign ready_o   = (r_state == MDU_IDLE);
    assign busy_o    = !ready_o;
    assign valid_o   = r_valid;
    assign result_o  = r_result;
    assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_kamus_mdu.sv
// Directed bench for kamus_mdu: XLEN=32 instance for function/handshake/flush/reset,
// plus an XLEN=64 instance for the wide divide.
module tb_kamus_mdu;
    import kamus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i;
    logic [5:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  rd_i;
    logic        ready_o, busy_o, valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    logic        v64, flush64;
    logic [5:0]  op64;
    logic [63:0] a64, b64;
    logic [4:0]  rd64;
    logic        ready64, busy64, valid64;
    logic [63:0] res64;
    logic [4:0]  rdo64;

    int errors = 0;
    int checks = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (valid_o === 1'b1) vcnt++;

    kamus_mdu #(.XLEN(32), .OP_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .operation_i(op_i), .rs1_data_i(a_i), .rs2_data_i(b_i), .rd_addr_i(rd_i),
        .flush_i(flush_i), .busy_o(busy_o), .valid_o(valid_o),
        .result_o(result_o), .rd_addr_o(rd_o)
    );

    kamus_mdu #(.XLEN(64), .OP_W(6)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(v64), .ready_o(ready64),
        .operation_i(op64), .rs1_data_i(a64), .rs2_data_i(b64), .rd_addr_i(rd64),
        .flush_i(flush64), .busy_o(busy64), .valid_o(valid64),
        .result_o(res64), .rd_addr_o(rdo64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input operation_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Returns the cycle (1 = first cycle after the accept edge) at which valid_o rose.
    task automatic wait_valid(input int limit, output int lat, output logic busy_ok);
        int n = 1;
        busy_ok = 1'b1;
        while (valid_o !== 1'b1 && n < limit) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic run(input string tag, input operation_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic bok;
        issue(op, a, b, rd);
        wait_valid(100, lat, bok);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, {32'h0, result_o}, {32'h0, exp});
        check({tag, "_rd"}, {59'h0, rd_o}, {59'h0, rd});
        check({tag, "_busy"}, {63'h0, bok & busy_o}, 64'h1);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {62'h0, valid_o, ready_o}, 64'h1);
    endtask

    initial begin
        int   n;
        int   vbase;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = OP_MUL;
        a_i = '0; b_i = '0; rd_i = '0;
        v64 = 1'b0; flush64 = 1'b0; op64 = OP_MUL; a64 = '0; b64 = '0; rd64 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {27'h0, ready_o, busy_o, valid_o, rd_o, result_o}, {27'h0, 3'b100, 5'd0, 32'd0});
        @(negedge clk); rst = 1'b0;

        // multiply
        run("mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 2);
        run("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 2);
        run("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, 2);
        run("mulh",   OP_MULH,   32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 2);

        // divide
        run("div",    OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run("rem",    OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run("divu",   OP_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       33);
        run("remu",   OP_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        33);
        run("divnp",  OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, 33);
        run("remnp",  OP_REM,    32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        33);

        // special cases
        run("divu0",  OP_DIVU,   32'h1234,     32'd0,        5'd11, 32'hFFFFFFFF, 1);
        run("remu0",  OP_REMU,   32'h1234,     32'd0,        5'd12, 32'h1234,     1);
        run("div0",   OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFFF, 1);
        run("rem0",   OP_REM,    32'hFFFFFFF9, 32'd0,        5'd14, 32'hFFFFFFF9, 1);
        run("divovf", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run("removf", OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1);

        // flush 10 cycles into a divide, then an immediate multiply
        vbase = vcnt;
        issue(OP_DIV, 32'd100, 32'd7, 5'd20);
        repeat (9) @(posedge clk);
        @(negedge clk); flush_i = 1'b1;
        @(posedge clk); #1; flush_i = 1'b0;
        check("flush_ready", {63'h0, ready_o}, 64'h1);
        check("flush_hold", {27'h0, valid_o, rd_o, result_o}, {27'h0, 1'b0, 5'd16, 32'h0});
        run("flushmul", OP_MUL, 32'd6, 32'd7, 5'd21, 32'd42, 2);
        repeat (40) @(posedge clk);
        #1;
        check("flush_novalid", 64'(vcnt - vbase), 64'd1);

        // handshake: valid_i held with changing operands while busy
        vbase = vcnt;
        @(negedge clk);
        valid_i = 1'b1; op_i = OP_MUL; a_i = 32'd3; b_i = 32'd5; rd_i = 5'd22;
        @(posedge clk); #1;
        op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd0; rd_i = 5'd23;
        check("hs_busy", {62'h0, busy_o, ready_o}, 64'h2);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("hs_first", {26'h0, valid_o, rd_o, result_o}, {26'h0, 1'b1, 5'd22, 32'd15});
        @(posedge clk); #1;
        check("hs_width", {62'h0, valid_o, ready_o}, 64'h1);
        repeat (3) @(posedge clk);
        #1;
        check("hs_count", {31'h0, ready_o, 32'(vcnt - vbase)}, {31'h0, 1'b1, 32'd1});

        // asynchronous reset mid-divide
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd24);
        repeat (5) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check("arst", {27'h0, ready_o, busy_o, valid_o, rd_o, result_o}, {27'h0, 3'b100, 5'd0, 32'd0});
        @(negedge clk); rst = 1'b0;

        // XLEN=64 unsigned divide
        @(negedge clk);
        v64 = 1'b1; op64 = OP_DIVU; a64 = 64'h8000000000000000; b64 = 64'd3; rd64 = 5'd17;
        @(posedge clk); #1;
        v64 = 1'b0;
        n = 1;
        while (valid64 !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("d64_lat", 64'(n), 64'd65);
        check("d64_res", res64, 64'h2AAAAAAAAAAAAAAA);
        check("d64_rd", {59'h0, rdo64}, {59'h0, 5'd17});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kamus_mdu.md
# kamus_mdu

Parametrised multi-cycle multiply/divide unit (RV32M/RV64M) that sits beside the single-cycle EX datapath. It accepts M-extension operations from ID-EX over a valid/ready handshake and holds the pipeline via `ready_o`/`busy_o` while working. Multiplies complete in a fixed 2 cycles. Divides use an XLEN-iteration radix-2 restoring divider with early-out for the spec's special cases. Each result leaves as a single-cycle `valid_o` pulse toward EX-MEM.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; legal values 32 or 64.
- `OP_W`, 6: width of the operation code; matches the EX `operation` field.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  request valid from ID-EX.
- `ready_o`  out  1  unit can accept; high only in IDLE.
- `operation_i`  in  OP_W  one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `rs1_data_i`  in  XLEN  dividend / multiplicand.
- `rs2_data_i`  in  XLEN  divisor / multiplier.
- `rd_addr_i`  in  5  destination register; carried through to the output.
- `flush_i`  in  1  abort any in-flight operation (branch taken / trap).
- `busy_o`  out  1  operation in flight; equals `!ready_o`; the hazard unit uses it to stall ID.
- `valid_o`  out  1  one-cycle result strobe.
- `result_o`  out  XLEN  result; holds its value until the next completion.
- `rd_addr_o`  out  5  destination register of the current result.

## Operation
- **Accept:** a request is accepted on an edge where `valid_i && ready_o && !flush_i`. On acceptance the unit latches:
  - the operation and `rd_addr_i`;
  - the operand signs (signed ops only);
  - the operand magnitudes (divide path).
- `valid_i` while `ready_o`=0 is ignored. No output backpressure: a consumer must take `valid_o` in the cycle it is high.
- **States and transitions:**
  - IDLE: on accept, MUL op → MUL; DIV/REM op → DIV, or → DONE when a special case applies.
  - MUL: → DONE after one cycle.
  - DIV: → DONE when the iteration counter reaches XLEN-1.
  - DONE: → IDLE unconditionally.
- **Multiply:**
  - Operands are extended to XLEN+1 bits: sign-extended for signed sources (MULH: both; MULHSU: rs1 only), zero-extended otherwise.
  - The signed 2·XLEN product is registered in MUL.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- **Divide:**
  - One quotient bit per cycle. The counter runs 0..XLEN-1 and is `$clog2(XLEN)` bits wide.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Negation is applied on the DIV→DONE transition.
- **Special cases** (detected at accept, no iteration):
  - Divisor = 0: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): quotient = rs1; remainder = 0.
- **Flush:** `flush_i` in any state forces IDLE on the next edge and suppresses `valid_o`. `result_o` and `rd_addr_o` keep their old values. `flush_i` together with `valid_i` in IDLE means no accept.
- **Reset:** mid-operation reset abandons the work immediately.

## Timing
- **Reset values:**
  - state IDLE, `ready_o`=1, `busy_o`=0, `valid_o`=0
  - `result_o`=0, `rd_addr_o`=0, divide counter 0.
- **Latency**, measured from the accept edge to the cycle `valid_o`=1:
  - multiply: 2 cycles;
  - normal divide: XLEN+1 cycles;
  - special-case divide: 1 cycle.
- `ready_o` returns high the cycle after `valid_o`. Back-to-back throughput is therefore 1 operation per 3 cycles for multiply and per XLEN+2 cycles for divide.
- `valid_o`, `result_o` and `rd_addr_o` are registered outputs. `ready_o` and `busy_o` are decoded from the state register only and never depend combinationally on `valid_i`.

## Structure
- The shared package `kamus_pkg` gains:
  - the M-extension members of `operation_e`;
  - `mdu_state_e` (IDLE, MUL, DIV, DONE);
  - `XLEN_DEFAULT`.
- Sub-module `kamus_div_iter`: the restoring divide datapath.
  - Holds the remainder/quotient shift registers and the trial subtract.
  - Controls: `start`, `step`; outputs: unsigned quotient and remainder.
- The FSM, sign handling and multiplier stay in `kamus_mdu`.

## Test plan
- **Multiply:** MUL rs1=7, rs2=0xFFFFFFFD (-3), XLEN=32 → `valid_o` 2 cycles after accept, `result_o`=0xFFFFFFEB. Then MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE, and MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **Signed divide:** DIV rs1=0xFFFFFFF9 (-7), rs2=2 → `result_o`=0xFFFFFFFD at cycle 33 after accept. The same operands with REM → 0xFFFFFFFF. `busy_o`=1 throughout.
- **Special cases:**
  - DIVU 0x1234/0 → 0xFFFFFFFF one cycle after accept.
  - REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- **Flush:** assert `flush_i` 10 cycles into a DIV → no `valid_o` ever appears for that op; `ready_o`=1 on the next cycle; an immediately following MUL completes correctly with its own `rd_addr_o`.
- **Handshake:** hold `valid_i`=1 with changing operands while busy → only the first request is accepted; `valid_o` is exactly one cycle wide.
- **Reset and width:**
  - Assert `rst_i` asynchronously mid-DIV → all outputs reach reset values without waiting for a clock edge.
  - XLEN=64: DIVU 2^63/3 → 0x2AAAAAAAAAAAAAAA at cycle 65.
